// File: rtl/upower_control_fsm_pkg.sv
// Shared definitions for the uPOWER multi-cycle control unit:
// opcode / XO constants, ALU_OP encodings, state encoding and the
// decoded-instruction and registered-control bundles.
package upower_control_fsm_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_LD    = 6'd58;
    localparam logic [5:0] OP_STD   = 6'd62;
    localparam logic [5:0] OP_ADDI  = 6'd14;
    localparam logic [5:0] OP_ANDI  = 6'd28;
    localparam logic [5:0] OP_ORI   = 6'd24;
    localparam logic [5:0] OP_XFORM = 6'd31;

    // X-form extended opcodes (instr[10:1])
    localparam logic [9:0] XO_ADD  = 10'd266;
    localparam logic [9:0] XO_SUBF = 10'd40;
    localparam logic [9:0] XO_AND  = 10'd28;
    localparam logic [9:0] XO_OR   = 10'd444;

    // ALU_64 operation select
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       is_ld;
        logic       is_st;
        logic       reg_dst;
        logic       alu_src;
        logic       xo;
        logic [3:0] alu_op;
    } decode_t;

    // Every control output, registered as one bundle
    typedef struct packed {
        logic       pc_en;
        logic       ir_load;
        logic [3:0] alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic       xo;
        logic       busy;
        logic       illegal;
        logic       mem_timeout;
        logic       halted;
    } ctrl_t;

    function automatic decode_t mk_dec(input logic is_ld, input logic is_st,
                                       input logic reg_dst, input logic alu_src,
                                       input logic xo, input logic [3:0] alu_op);
        decode_t d;
        d.legal   = 1'b1;
        d.is_ld   = is_ld;
        d.is_st   = is_st;
        d.reg_dst = reg_dst;
        d.alu_src = alu_src;
        d.xo      = xo;
        d.alu_op  = alu_op;
        return d;
    endfunction

endpackage

// File: rtl/upower_main_decoder.sv
// Combinational instruction decoder: primary opcode plus X-form XO
// to {legal, is_ld, is_st, RegDst, ALUSrc, XO, ALU_OP}.
module upower_main_decoder
    import upower_control_fsm_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [9:0] i_xo,
    output decode_t    o_dec
);

    // Table lookup; anything not listed decodes as illegal (all zero)
    always_comb begin
        o_dec = '0;
        case (i_opcode)
            OP_LD:    o_dec = mk_dec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD);
            OP_STD:   o_dec = mk_dec(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, ALU_ADD);
            OP_ADDI:  o_dec = mk_dec(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ALU_ADD);
            OP_ANDI:  o_dec = mk_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_AND);
            OP_ORI:   o_dec = mk_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_OR);
            OP_XFORM: begin
                case (i_xo)
                    XO_ADD:  o_dec = mk_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ALU_ADD);
                    XO_SUBF: o_dec = mk_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ALU_SUB);
                    XO_AND:  o_dec = mk_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_AND);
                    XO_OR:   o_dec = mk_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OR);
                    default: o_dec = '0;
                endcase
            end
            default:  o_dec = '0;
        endcase
    end

endmodule

// File: rtl/upower_control_fsm.sv
// Multi-cycle control FSM for the uPOWER load/store/R/I datapath.
// Sequences FETCH->DECODE->EXEC->(MEM)->WB with every output registered.
// Outputs are computed from the next state, so each strobe is visible in
// the cycle of the state it belongs to. Decisions that depend on mem_ack
// sampled at the end of MEM (std completion, timeout) show their pc_en /
// mem_timeout pulse in the following FETCH cycle.
// Optional build macro: UPOWER_FSM_PERF_EN adds instr_retired / cycle_count.
module upower_control_fsm
    import upower_control_fsm_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16,
    parameter int CNT_W        = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        ir_load,
    output logic [3:0]  ALU_OP,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic        RegDst,
    output logic        XO,
    output logic        busy,
    output logic        illegal,
    output logic        mem_timeout,
    output logic        halted
`ifdef UPOWER_FSM_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_retired,
    output logic [CNT_W-1:0] cycle_count
`endif
);

    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    state_t             r_state, w_state_next;
    logic [WAIT_W-1:0]  r_wait, w_wait_next;
    ctrl_t              r_ctrl, w_ctrl_next;
    decode_t            w_dec;
    logic               w_is_zero;

    upower_main_decoder u_dec (
        .i_opcode (instruction[31:26]),
        .i_xo     (instruction[10:1]),
        .o_dec    (w_dec)
    );

    assign w_is_zero = (instruction == 32'h0);

    // State, MEM wait counter and registered control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            r_ctrl  <= w_ctrl_next;
        end
    end

    // Next state and the outputs belonging to that next state
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_ctrl_next  = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next        = ST_FETCH;
                    w_ctrl_next.ir_load = 1'b1;
                    w_ctrl_next.busy    = 1'b1;
                end
            end
            ST_FETCH: begin
                // Instruction is already stable here, so an illegal
                // encoding is flagged during the DECODE cycle itself
                w_state_next     = ST_DECODE;
                w_ctrl_next.busy = 1'b1;
                if (!w_is_zero && !w_dec.legal) begin
                    w_ctrl_next.illegal = 1'b1;
                    w_ctrl_next.pc_en   = 1'b1;
                end
            end
            ST_DECODE: begin
                if (w_is_zero) begin
                    w_state_next       = ST_HALT;
                    w_ctrl_next.halted = 1'b1;
                end else if (!w_dec.legal) begin
                    w_state_next        = ST_FETCH;
                    w_ctrl_next.ir_load = 1'b1;
                    w_ctrl_next.busy    = 1'b1;
                end else begin
                    w_state_next        = ST_EXEC;
                    w_ctrl_next.busy    = 1'b1;
                    w_ctrl_next.alu_op  = w_dec.alu_op;
                    w_ctrl_next.alu_src = w_dec.alu_src;
                    w_ctrl_next.reg_dst = w_dec.reg_dst;
                    w_ctrl_next.xo      = w_dec.xo;
                end
            end
            ST_EXEC: begin
                w_ctrl_next.busy = 1'b1;
                {w_ctrl_next.alu_op, w_ctrl_next.alu_src, w_ctrl_next.reg_dst, w_ctrl_next.xo} =
                    {r_ctrl.alu_op, r_ctrl.alu_src, r_ctrl.reg_dst, r_ctrl.xo};
                if (w_dec.is_ld || w_dec.is_st) begin
                    w_state_next          = ST_MEM;
                    w_wait_next           = '0;
                    w_ctrl_next.mem_read  = w_dec.is_ld;
                    w_ctrl_next.mem_write = w_dec.is_st;
                end else begin
                    w_state_next          = ST_WB;
                    w_ctrl_next.reg_write = 1'b1;
                    w_ctrl_next.pc_en     = 1'b1;
                end
            end
            ST_MEM: begin
                w_ctrl_next.busy = 1'b1;
                if (mem_ack && r_ctrl.mem_read) begin
                    w_state_next           = ST_WB;
                    {w_ctrl_next.alu_op, w_ctrl_next.alu_src, w_ctrl_next.reg_dst, w_ctrl_next.xo} =
                        {r_ctrl.alu_op, r_ctrl.alu_src, r_ctrl.reg_dst, r_ctrl.xo};
                    w_ctrl_next.reg_write  = 1'b1;
                    w_ctrl_next.mem_to_reg = 1'b1;
                    w_ctrl_next.pc_en      = 1'b1;
                end else if (mem_ack || (r_wait == WAIT_LAST)) begin
                    // std completion or abandoned access: straight to FETCH
                    w_state_next            = ST_FETCH;
                    w_ctrl_next.ir_load     = 1'b1;
                    w_ctrl_next.pc_en       = 1'b1;
                    w_ctrl_next.mem_timeout = !mem_ack;
                end else begin
                    w_wait_next           = r_wait + WAIT_W'(1);
                    {w_ctrl_next.alu_op, w_ctrl_next.alu_src, w_ctrl_next.reg_dst, w_ctrl_next.xo} =
                        {r_ctrl.alu_op, r_ctrl.alu_src, r_ctrl.reg_dst, r_ctrl.xo};
                    w_ctrl_next.mem_read  = r_ctrl.mem_read;
                    w_ctrl_next.mem_write = r_ctrl.mem_write;
                end
            end
            ST_WB: begin
                w_state_next        = ST_FETCH;
                w_ctrl_next.ir_load = 1'b1;
                w_ctrl_next.busy    = 1'b1;
            end
            ST_HALT: begin
                w_ctrl_next.halted = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign pc_en       = r_ctrl.pc_en;
    assign ir_load     = r_ctrl.ir_load;
    assign ALU_OP      = r_ctrl.alu_op;
    assign RegWrite    = r_ctrl.reg_write;
    assign MemRead     = r_ctrl.mem_read;
    assign MemWrite    = r_ctrl.mem_write;
    assign MemtoReg    = r_ctrl.mem_to_reg;
    assign ALUSrc      = r_ctrl.alu_src;
    assign RegDst      = r_ctrl.reg_dst;
    assign XO          = r_ctrl.xo;
    assign busy        = r_ctrl.busy;
    assign illegal     = r_ctrl.illegal;
    assign mem_timeout = r_ctrl.mem_timeout;
    assign halted      = r_ctrl.halted;

`ifdef UPOWER_FSM_PERF_EN
    logic [CNT_W-1:0] r_instr_retired, r_cycle_count;
    logic             w_retire;

    // A retirement is a pc_en pulse that is neither illegal nor a timeout
    assign w_retire = w_ctrl_next.pc_en & ~w_ctrl_next.illegal & ~w_ctrl_next.mem_timeout;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_retired <= '0;
            r_cycle_count   <= '0;
        end else begin
            if (w_retire && (r_instr_retired != '1)) begin
                r_instr_retired <= r_instr_retired + CNT_W'(1);
            end
            if (r_ctrl.busy && (r_cycle_count != '1)) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
        end
    end

    assign instr_retired = r_instr_retired;
    assign cycle_count   = r_cycle_count;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_upower_control_fsm.sv
// Self-checking bench for upower_control_fsm. A reference model builds
// the expected per-cycle output trace of each instruction from its class
// (ALU / ld / std / illegal / halt) and memory-ack delay, and every cycle
// is compared against the DUT. Directed cases first, then random ones.
// Build with UPOWER_FSM_PERF_EN to also check the performance counters.
module tb_upower_control_fsm;

    localparam int MAXW = 16;

    typedef struct packed {
        logic       pc_en;
        logic       ir_load;
        logic [3:0] alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic       xo;
        logic       busy;
        logic       illegal;
        logic       mem_timeout;
        logic       halted;
    } outs_t;

    // Reference decode table: opcode, xo, {RegDst,ALUSrc,XO}, ALU_OP
    localparam int         TB_OP    [9] = '{58, 62, 14, 28, 24, 31, 31, 31, 31};
    localparam int         TB_XO    [9] = '{0, 0, 0, 0, 0, 266, 40, 28, 444};
    localparam logic [2:0] TB_FLAGS [9] = '{3'b110, 3'b111, 3'b111, 3'b010, 3'b010,
                                            3'b101, 3'b101, 3'b001, 3'b001};
    localparam logic [3:0] TB_ALU   [9] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001,
                                            4'b0010, 4'b0110, 4'b0000, 4'b0001};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] instruction;
    logic        mem_ack;
    logic        pc_en, ir_load, RegWrite, MemRead, MemWrite, MemtoReg;
    logic        ALUSrc, RegDst, XO, busy, illegal, mem_timeout, halted;
    logic [3:0]  ALU_OP;
`ifdef UPOWER_FSM_PERF_EN
    logic [31:0] instr_retired, cycle_count;
`endif

    int checks = 0;
    int errors = 0;
    logic carry_pc = 1'b0;
    logic carry_to = 1'b0;
    int cnt_rw, cnt_mr, cnt_mw, cnt_ill;

    upower_control_fsm #(.MEM_WAIT_MAX(MAXW), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instruction (instruction),
        .mem_ack     (mem_ack),
        .pc_en       (pc_en),
        .ir_load     (ir_load),
        .ALU_OP      (ALU_OP),
        .RegWrite    (RegWrite),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrc      (ALUSrc),
        .RegDst      (RegDst),
        .XO          (XO),
        .busy        (busy),
        .illegal     (illegal),
        .mem_timeout (mem_timeout),
        .halted      (halted)
`ifdef UPOWER_FSM_PERF_EN
        ,
        .instr_retired (instr_retired),
        .cycle_count   (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic outs_t obs();
        outs_t o;
        o.pc_en = pc_en;          o.ir_load = ir_load;       o.alu_op = ALU_OP;
        o.reg_write = RegWrite;   o.mem_read = MemRead;      o.mem_write = MemWrite;
        o.mem_to_reg = MemtoReg;  o.alu_src = ALUSrc;        o.reg_dst = RegDst;
        o.xo = XO;                o.busy = busy;             o.illegal = illegal;
        o.mem_timeout = mem_timeout; o.halted = halted;
        return o;
    endfunction

    task automatic check_outs(input string tag, input outs_t o, input outs_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, o, e);
        end
    endtask

    task automatic check_val(input string tag, input longint o, input longint e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    function automatic int ref_lookup(input logic [31:0] w);
        for (int i = 0; i < 9; i++) begin
            if (int'(w[31:26]) == TB_OP[i] && (TB_OP[i] != 31 || int'(w[10:1]) == TB_XO[i]))
                return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int s;
        w = $urandom;
        s = $urandom_range(0, 11);
        if (s < 9) begin
            w[31:26] = 6'(TB_OP[s]);
            if (TB_OP[s] == 31) w[10:1] = 10'(TB_XO[s]);
        end else if (s == 9) begin
            do w[31:26] = 6'($urandom_range(1, 63));
            while (ref_lookup(w) >= 0 || w[31:26] == 6'd31);
        end else begin
            w[31:26] = 6'd31;
            do w[10:1] = 10'($urandom);
            while (ref_lookup(w) >= 0);
        end
        return w;
    endfunction

    // One cycle: compare, then drive this cycle's inputs and advance
    task automatic step(input string tag, input outs_t e, input logic [31:0] ins, input logic ack);
        outs_t o;
        o = obs();
        check_outs(tag, o, e);
        cnt_rw  += int'(o.reg_write);
        cnt_mr  += int'(o.mem_read);
        cnt_mw  += int'(o.mem_write);
        cnt_ill += int'(o.illegal);
        instruction = ins;
        mem_ack     = ack;
        start       = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    // Build the expected trace for one instruction and run it.
    // k = MEM cycle in which mem_ack is high; k > MAXW means never.
    task automatic run_instr(input string name, input logic [31:0] ins, input int k, input int max_cyc);
        outs_t q[$];
        logic  aq[$];
        outs_t e, f;
        int idx, n;
        bit is_halt, is_ill, is_ld, is_st;
        idx     = ref_lookup(ins);
        is_halt = (ins == 32'h0);
        is_ill  = !is_halt && (idx < 0);
        is_ld   = (idx == 0);
        is_st   = (idx == 1);
        f = '0;
        if (idx >= 0) begin
            f.alu_op = TB_ALU[idx];
            {f.reg_dst, f.alu_src, f.xo} = TB_FLAGS[idx];
        end
        e = '0; e.ir_load = 1'b1; e.busy = 1'b1; e.pc_en = carry_pc; e.mem_timeout = carry_to;
        q.push_back(e); aq.push_back(1'($urandom_range(0, 1)));
        carry_pc = 1'b0; carry_to = 1'b0;
        e = '0; e.busy = 1'b1;
        if (is_ill) begin e.illegal = 1'b1; e.pc_en = 1'b1; end
        q.push_back(e); aq.push_back(1'($urandom_range(0, 1)));
        if (is_halt) begin
            e = '0; e.halted = 1'b1;
            for (int j = 0; j < 6; j++) begin q.push_back(e); aq.push_back(1'($urandom_range(0, 1))); end
        end else if (!is_ill) begin
            e = f; e.busy = 1'b1;
            q.push_back(e); aq.push_back(1'($urandom_range(0, 1)));
            if (!is_ld && !is_st) begin
                e = f; e.busy = 1'b1; e.reg_write = 1'b1; e.pc_en = 1'b1;
                q.push_back(e); aq.push_back(1'($urandom_range(0, 1)));
            end else begin
                for (int m = 1; m <= MAXW && m <= k; m++) begin
                    e = f; e.busy = 1'b1; e.mem_read = is_ld; e.mem_write = is_st;
                    q.push_back(e); aq.push_back(m == k);
                end
                if (k > MAXW) begin
                    carry_pc = 1'b1; carry_to = 1'b1;
                end else if (is_ld) begin
                    e = f; e.busy = 1'b1; e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.pc_en = 1'b1;
                    q.push_back(e); aq.push_back(1'($urandom_range(0, 1)));
                end else begin
                    carry_pc = 1'b1;
                end
            end
        end
        n = q.size();
        if (max_cyc > 0 && max_cyc < n) n = max_cyc;
        for (int j = 0; j < n; j++) step($sformatf("%s c%0d", name, j), q[j], ins, aq[j]);
    endtask

    task automatic clear_counts();
        cnt_rw = 0; cnt_mr = 0; cnt_mw = 0; cnt_ill = 0;
    endtask

    // Leave IDLE: one edge with start high, ending in the first FETCH cycle
    task automatic kick();
        start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        int k, s;
        rst = 1'b0; start = 1'b0; instruction = 32'h0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset_state", obs(), '0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check_outs("idle_no_start", obs(), '0);

        kick();
        clear_counts();
        run_instr("addi", 32'h3A20_0014, 0, 0);
        check_val("addi_regwrite_cycles", cnt_rw, 1);

        clear_counts();
        run_instr("ld3", 32'hE822_0004, 3, 0);
        check_val("ld_memread_cycles", cnt_mr, 3);
        check_val("ld_regwrite_cycles", cnt_rw, 1);

        clear_counts();
        run_instr("std1", 32'hF8A2_0008, 1, 0);
        check_val("std_memwrite_cycles", cnt_mw, 1);
        check_val("std_regwrite_cycles", cnt_rw, 0);

        clear_counts();
        run_instr("ill_op1", 32'h0420_0000, 0, 0);
        check_val("ill_pulses", cnt_ill, 1);
        check_val("ill_writes", cnt_rw + cnt_mw, 0);

        clear_counts();
        run_instr("std_to", 32'hF8A2_0008, MAXW + 1, 0);
        check_val("std_to_memwrite_cycles", cnt_mw, MAXW);

        for (int i = 0; i < 120; i++) begin
            w = gen_instr();
            s = $urandom_range(0, 9);
            k = (s == 0) ? MAXW + 1 : (s == 1) ? MAXW : $urandom_range(1, 5);
            run_instr($sformatf("rnd%0d_%08h_k%0d", i, w, k), w, k, 0);
        end

        // Asynchronous reset in the middle of a ld's MEM phase
        clear_counts();
        run_instr("ld_rst", 32'hE822_0004, 5, 5);
        #2 rst = 1'b0;
        #1;
        check_outs("rst_async", obs(), '0);
        start = 1'b0; mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        carry_pc = 1'b0; carry_to = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            check_outs($sformatf("after_rst c%0d", j), obs(), '0);
        end

        kick();
        run_instr("p_addi", 32'h3A20_0014, 0, 0);
        run_instr("p_ld", 32'hE822_0004, 1, 0);
        run_instr("p_ill", 32'h0420_0000, 0, 0);
`ifdef UPOWER_FSM_PERF_EN
        check_val("instr_retired", longint'(instr_retired), 2);
        check_val("cycle_count", longint'(cycle_count), 11);
`endif

        run_instr("halt", 32'h0, 0, 0);
        check_val("halt_busy", longint'(busy), 0);
        check_val("halt_halted", longint'(halted), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
